// File: rtl/seg_display_arbiter.sv
// Fixed-priority owner of the shared 4-digit 7-segment display. Owners change only
// on frame boundaries; anodes are time-multiplexed and per-digit blink is applied.
module seg_display_arbiter #(
    parameter int SCAN_DIV  = 65536,
    parameter int BLINK_DIV = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [15:0] val2,
    input  logic [15:0] val3,
    input  logic [3:0]  blink0,
    input  logic [3:0]  blink1,
    input  logic [3:0]  blink2,
    input  logic [3:0]  blink3,
    output logic [3:0]  grant,
    output logic [3:0]  anode,
    output logic [3:0]  digit,
    output logic        frame_tick
);

    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int FCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_DIV - 1);

    // Alarm service (bit 3) outranks the others, then bits 0, 1, 2.
    function automatic logic [3:0] pick_winner(input logic [3:0] r);
        logic [3:0] w;
        if (r[3])      w = 4'b1000;
        else if (r[0]) w = 4'b0001;
        else if (r[1]) w = 4'b0010;
        else if (r[2]) w = 4'b0100;
        else           w = 4'b0000;
        return w;
    endfunction

    logic [1:0]        idx_r, idx_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [FCNT_W-1:0] fcnt_r, fcnt_s;
    logic              blink_on_r, blink_on_s;
    logic [3:0]        grant_s, winner_s;
    logic              tick_s;
    logic [15:0]       val_sel_s;
    logic [3:0]        blink_sel_s, nib_s, anode_s, digit_s;
    logic              blank_s;

    assign winner_s = pick_winner(req);

    // Next-state: scan/frame counters, boundary re-arbitration and blink phase.
    always_comb begin
        grant_s    = grant;
        idx_s      = idx_r;
        cnt_s      = cnt_r;
        fcnt_s     = fcnt_r;
        blink_on_s = blink_on_r;
        tick_s     = 1'b0;
        if (grant == 4'b0000) begin
            if (req != 4'b0000) begin
                grant_s    = winner_s;
                idx_s      = 2'd0;
                cnt_s      = '0;
                fcnt_s     = '0;
                blink_on_s = 1'b1;
            end else begin
                grant_s = 4'b0000;
            end
        end else begin
            if (cnt_r == CNT_LAST) begin
                cnt_s = '0;
                idx_s = idx_r + 2'd1;
            end else begin
                cnt_s = cnt_r + CNT_W'(1);
            end
            if ((cnt_r == CNT_LAST) && (idx_r == 2'd3)) begin
                tick_s  = 1'b1;
                grant_s = winner_s;
                if (fcnt_r == FCNT_LAST) begin
                    fcnt_s     = '0;
                    blink_on_s = ~blink_on_r;
                end else begin
                    fcnt_s = fcnt_r + FCNT_W'(1);
                end
                // A new owner always starts with a fresh, visible blink phase.
                if ((winner_s != 4'b0000) && (winner_s != grant)) begin
                    fcnt_s     = '0;
                    blink_on_s = 1'b1;
                end else begin
                    blink_on_s = blink_on_s;
                end
            end else begin
                tick_s = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant      <= 4'b0000;
            idx_r      <= 2'd0;
            cnt_r      <= '0;
            fcnt_r     <= '0;
            blink_on_r <= 1'b1;
        end else begin
            grant      <= grant_s;
            idx_r      <= idx_s;
            cnt_r      <= cnt_s;
            fcnt_r     <= fcnt_s;
            blink_on_r <= blink_on_s;
        end
    end

    // Display selection from the current owner; invalid BCD and blink-off blank the digit.
    always_comb begin
        val_sel_s   = 16'h0000;
        blink_sel_s = 4'b0000;
        case (grant)
            4'b0001: begin val_sel_s = val0; blink_sel_s = blink0; end
            4'b0010: begin val_sel_s = val1; blink_sel_s = blink1; end
            4'b0100: begin val_sel_s = val2; blink_sel_s = blink2; end
            4'b1000: begin val_sel_s = val3; blink_sel_s = blink3; end
            default: begin val_sel_s = 16'h0000; blink_sel_s = 4'b0000; end
        endcase
        nib_s   = val_sel_s[{idx_r, 2'b00} +: 4];
        blank_s = (grant == 4'b0000) || (nib_s > 4'd9) ||
                  (blink_sel_s[idx_r] && !blink_on_r);
        if (blank_s) begin
            anode_s = 4'b1111;
            digit_s = 4'h0;
        end else begin
            anode_s = ~(4'b0001 << idx_r);
            digit_s = nib_s;
        end
    end

    // Output register: display lags the scan state by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            anode      <= 4'b1111;
            digit      <= 4'h0;
            frame_tick <= 1'b0;
        end else begin
            anode      <= anode_s;
            digit      <= digit_s;
            frame_tick <= tick_s;
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with SCAN_DIV=4, BLINK_DIV=2 (16-cycle frames).
module tb_seg_display_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] val0, val1, val2, val3;
    logic [3:0]  blink0, blink1, blink2, blink3;
    logic [3:0]  grant, anode, digit;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    seg_display_arbiter #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
        .clk(clk), .reset(reset), .req(req),
        .val0(val0), .val1(val1), .val2(val2), .val3(val3),
        .blink0(blink0), .blink1(blink1), .blink2(blink2), .blink3(blink3),
        .grant(grant), .anode(anode), .digit(digit), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Steps one frame from just after a boundary (or grant) edge. exp_an/exp_dig hold
    // {idx3,idx2,idx1,idx0} nibbles; grant must equal g_exp until the closing edge.
    task automatic run_frame(input string tag, input logic [15:0] exp_an,
                             input logic [15:0] exp_dig, input logic [3:0] g_exp,
                             input logic [3:0] g_end, input int mid_step,
                             input logic [3:0] mid_req);
        for (int j = 0; j < 16; j++) begin
            if (j == mid_step) req = mid_req;
            tick();
            chk({tag, "_anode"}, anode, exp_an[(j/4)*4 +: 4]);
            chk({tag, "_digit"}, digit, exp_dig[(j/4)*4 +: 4]);
            chk({tag, "_tick"}, {3'b000, frame_tick}, (j == 15) ? 4'd1 : 4'd0);
            chk({tag, "_grant"}, grant, (j == 15) ? g_end : g_exp);
        end
    endtask

    initial begin
        reset = 1'b1; req = 4'b0000;
        val0 = 16'h0000; val1 = 16'h0000; val2 = 16'h0000; val3 = 16'h0000;
        blink0 = 4'b0000; blink1 = 4'b0000; blink2 = 4'b0000; blink3 = 4'b0000;
        tick(); tick();
        chk("rst_grant", grant, 4'b0000);
        chk("rst_anode", anode, 4'b1111);
        chk("rst_digit", digit, 4'h0);
        chk("rst_tick", {3'b000, frame_tick}, 4'd0);

        // 1: single requester, full scan of 16'h1234
        reset = 1'b0; req = 4'b0001; val0 = 16'h1234;
        tick();
        chk("t1_grant", grant, 4'b0001);
        chk("t1_anode_lag", anode, 4'b1111);
        run_frame("t1", 16'h7BDE, 16'h1234, 4'b0001, 4'b0001, -1, 4'b0000);

        // 2: alarm requests at idx 1, waits for the boundary
        val3 = 16'h5678;
        run_frame("t2", 16'h7BDE, 16'h1234, 4'b0001, 4'b1000, 5, 4'b1001);
        run_frame("t2_new", 16'h7BDE, 16'h5678, 4'b1000, 4'b0010, 2, 4'b0010);

        // 3: requester 1 with digit 2 blinking
        val1 = 16'h0550; blink1 = 4'b0100;
        run_frame("t3_on1", 16'h7BDE, 16'h0550, 4'b0010, 4'b0010, -1, 4'b0000);
        run_frame("t3_on2", 16'h7BDE, 16'h0550, 4'b0010, 4'b0010, -1, 4'b0000);
        run_frame("t3_off1", 16'h7FDE, 16'h0050, 4'b0010, 4'b0010, -1, 4'b0000);
        run_frame("t3_off2", 16'h7FDE, 16'h0050, 4'b0010, 4'b0010, -1, 4'b0000);
        val0 = 16'h12A4;
        run_frame("t3_on3", 16'h7BDE, 16'h0550, 4'b0010, 4'b0001, 2, 4'b0001);

        // 4: invalid BCD nibble in idx 1 is blanked
        run_frame("t4", 16'h7BFE, 16'h1204, 4'b0001, 4'b0001, -1, 4'b0000);

        // 5: owner drops mid-frame, display finishes the frame then idles
        run_frame("t5", 16'h7BFE, 16'h1204, 4'b0001, 4'b0000, 6, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("t5_idle_grant", grant, 4'b0000);
            chk("t5_idle_anode", anode, 4'b1111);
            chk("t5_idle_digit", digit, 4'h0);
            chk("t5_idle_tick", {3'b000, frame_tick}, 4'd0);
        end

        // 6: reset mid-frame with req held, then clean restart at idx 0
        val0 = 16'h1234; req = 4'b0001;
        tick();
        chk("t6_grant", grant, 4'b0001);
        repeat (6) tick();
        chk("t6_mid_anode", anode, 4'b1101);
        reset = 1'b1;
        tick();
        chk("t6_rst_grant", grant, 4'b0000);
        chk("t6_rst_anode", anode, 4'b1111);
        chk("t6_rst_digit", digit, 4'h0);
        chk("t6_rst_tick", {3'b000, frame_tick}, 4'd0);
        reset = 1'b0;
        tick();
        chk("t6_regrant", grant, 4'b0001);
        chk("t6_regrant_anode", anode, 4'b1111);
        run_frame("t6", 16'h7BDE, 16'h1234, 4'b0001, 4'b0001, -1, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the single 4-digit 7-segment display between the four service blocks (time set, alarm set, stopwatch, alarm/mini-game). Each service raises a request with a 16-bit BCD value and a per-digit blink mask. The arbiter grants one requester by fixed priority, switching only on frame boundaries so no frame is torn, and time-multiplexes the four anodes. It drives the active-low anode lines and a 4-bit BCD digit into the existing number-to-segment decoder.

## Interface
Parameters:
- SCAN_DIV, 65536: clk cycles each digit stays lit (≥2).
- BLINK_DIV, 64: frames per blink half-period (≥1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  4  request per service; bit 3 = service 4 (alarm), bit 0 = service 1.
- val0..val3  in  16 each  BCD value of requester i; [3:0] is the rightmost digit, [15:12] the leftmost.
- blink0..blink3  in  4 each  blink mask of requester i; bit k set means digit k blinks.
- grant  out  4  one-hot current owner; 0000 means idle.
- anode  out  4  active-low digit enables; 1110 selects the rightmost digit.
- digit  out  4  BCD value for the decoder.
- frame_tick  out  1  1-cycle pulse as the last digit (index 3) period ends.

## Operation
- State: grant register, 2-bit digit index idx, scan counter cnt (0..SCAN_DIV-1), frame counter fcnt (0..BLINK_DIV-1), blink_on flag.
- Reset: grant=0000, idx=0, cnt=0, fcnt=0, blink_on=1, anode=1111, digit=0, frame_tick=0.
- Priority: req[3] first, then req[0], req[1], req[2]. The alarm service always wins at a boundary.
- IDLE (grant=0000):
  - cnt, idx, fcnt and blink_on hold.
  - anode=1111 (registered).
  - When any req bit is high in cycle N, grant loads the priority winner at edge N+1, and idx=0, cnt=0, fcnt=0, blink_on=1.
- ACTIVE (grant≠0000):
  - cnt increments each cycle.
  - At cnt=SCAN_DIV-1: cnt→0 and idx→idx+1 (wraps 3→0).
  - Frame boundary is the cycle where cnt=SCAN_DIV-1 and idx=3. In that cycle:
    - frame_tick=1 at the next edge.
    - Re-arbitrate: grant loads the priority winner among current req, or 0000 if req=0000.
    - fcnt advances. When fcnt was BLINK_DIV-1, fcnt→0 and blink_on toggles.
    - If grant changes owner (not to 0000), fcnt→0 and blink_on→1.
  - A granted requester dropping req mid-frame does not change grant; its val/blink are still displayed until the boundary.
  - A higher-priority req mid-frame waits for the boundary.
- Display, registered each cycle from current state (g = granted index):
  - anode = ~(1<<idx), digit = val_g[4·idx+3:4·idx].
  - Force anode=1111 and digit=0 in any of these cases: grant=0000; val_g nibble > 9 (invalid BCD); blink_g[idx]=1 and blink_on=0.
- val/blink are sampled live; they are not latched at grant.

## Timing
- Outputs anode/digit lag the internal state (grant, idx) by exactly 1 cycle.
- Idle→active:
  - req rises in cycle N.
  - grant valid after edge N+1.
  - First lit anode (1110) after edge N+2.
  - Latency: 2 cycles.
- Digit period is SCAN_DIV cycles; frame is 4·SCAN_DIV cycles; blink half-period is BLINK_DIV frames.
- Owner change takes effect at a frame boundary only. The new owner's first digit (idx 0) appears 1 cycle after the boundary edge.
- All req low at a boundary: grant→0000 and anode=1111 one cycle later. Re-entry follows the idle→active rule.
- Simultaneous reset and req: reset wins.
- Reset mid-frame: all state returns to reset values at that edge; nothing persists.
- grant is never multi-hot. frame_tick never asserts while idle.

## Test plan
Bench parameters: SCAN_DIV=4, BLINK_DIV=2.
1. Reset, then req=0001 with val0=16'h1234 and blink0=0 → grant=0001 after 1 cycle. Anode sequence 1110,1101,1011,0111, each 4 cycles, with digit sequence 4,3,2,1. frame_tick pulses every 16 cycles.
2. While owner is requester 0, assert req=1001 at idx=1 → grant holds 0001 until the frame boundary. grant becomes 1000 at the boundary, and anode 1110 shows val3[3:0] 1 cycle later.
3. Owner requester 1, blink1=4'b0100, val1=16'h0550 → digit 2 is lit for 2 frames (blink_on=1), blanked for 2 frames (anode stays 1111 during idx 2), then lit again. Other digits are never blanked.
4. val0=16'h12A4 → during idx 1 the anode is 1111 and digit=0. Digits 0, 2 and 3 display 4, 2, 1.
5. Owner drops req mid-frame with no other requests → the display continues to the frame end. grant=0000 at the boundary, anode=1111 thereafter, and frame_tick stops.
6. Assert reset mid-frame with req still high → the next cycle shows grant=0000, anode=1111, digit=0. After reset deasserts, grant re-asserts 1 cycle later and starts at idx 0.
